// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared cache-port types for the page table walker memory arbiter,
// plus the two-way round-robin pick used to choose a requester.
package ptw_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
    } CacheReq;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
    } CacheResp;

    typedef enum logic [1:0] {
        USER       = 2'b00,
        SUPERVISOR = 2'b01,
        MACHINE    = 2'b11
    } modetype;

    // A lone requester always wins; on a tie the pointer decides.
    function automatic logic rr_pick(input logic ivalid, input logic dvalid, input logic ptr);
        return (ivalid && dvalid) ? ptr : dvalid;
    endfunction

endpackage

// File: rtl/ptw_mem_arbiter_if.sv
// Request and response halves of a cache port; the requester side is master
// of the request, the responder side is master of the response.
interface cache_req_if;
    import ptw_mem_arbiter_pkg::*;

    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              ready;

    modport master (output valid, addr, wen, wdata, input ready);
    modport slave  (input valid, addr, wen, wdata, output ready);
endinterface

interface cache_resp_if;
    import ptw_mem_arbiter_pkg::*;

    logic              valid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, rdata);
    modport slave  (input valid, rdata);
endinterface

// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction-side and
// data-side page table walkers, with one transaction outstanding at a time.
module ptw_mem_arbiter
    import ptw_mem_arbiter_pkg::*;
#(
    parameter bit LOG_ENABLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_req_if.slave   ireq,
    cache_resp_if.master iresp,
    cache_req_if.slave   dreq,
    cache_resp_if.master dresp,
    input  logic         ikill,
    input  logic         dkill,
    cache_req_if.master  memreq,
    cache_resp_if.slave  memresp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } statetype;

    statetype state, state_next;
    logic     owner, owner_next;
    logic     ptr, ptr_next;
    logic     drop, drop_next;
    CacheReq  s_req, s_req_next;

    logic     any_valid;
    logic     winner;
    logic     win_kill;
    logic     kill_owner;
    logic     fwd_valid;
    CacheReq  win_req;

    assign any_valid  = ireq.valid | dreq.valid;
    assign winner     = rr_pick(ireq.valid, dreq.valid, ptr);
    assign win_kill   = winner ? dkill : ikill;
    assign kill_owner = owner ? dkill : ikill;
    assign fwd_valid  = memresp.valid && !drop && !kill_owner;

    assign win_req = winner ? '{valid: 1'b1, addr: dreq.addr, wen: dreq.wen, wdata: dreq.wdata}
                            : '{valid: 1'b1, addr: ireq.addr, wen: ireq.wen, wdata: ireq.wdata};

    assign iresp.rdata = memresp.rdata;
    assign dresp.rdata = memresp.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
            drop  <= 1'b0;
            s_req <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
            drop  <= drop_next;
            s_req <= s_req_next;
        end
    end

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        ptr_next      = ptr;
        drop_next     = drop;
        s_req_next    = s_req;
        ireq.ready    = 1'b0;
        dreq.ready    = 1'b0;
        memreq.valid  = 1'b0;
        memreq.addr   = s_req.addr;
        memreq.wen    = s_req.wen;
        memreq.wdata  = s_req.wdata;
        iresp.valid   = 1'b0;
        dresp.valid   = 1'b0;

        case (state)
            IDLE: begin
                ireq.ready = !winner;
                dreq.ready = winner;
                // A killed winner still sees ready, but its request is not taken.
                if (any_valid && !win_kill) begin
                    s_req_next = win_req;
                    owner_next = winner;
                    drop_next  = 1'b0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                memreq.valid = s_req.valid;
                // Once memory has taken the request, a kill can only discard the response.
                if (memreq.ready) begin
                    drop_next  = kill_owner;
                    state_next = WAIT;
                end else if (kill_owner) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (kill_owner) begin
                    drop_next = 1'b1;
                end
                if (memresp.valid) begin
                    ptr_next   = ~owner;
                    state_next = IDLE;
                end
                iresp.valid = !owner && fwd_valid;
                dresp.valid = owner && fwd_valid;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    if (LOG_ENABLE) begin : g_log
        logic [4:0] debug_line;
        assign debug_line = {state, owner, ptr, drop};
    end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: single request, round-robin order,
// kill in ISSUE and WAIT, and reset during an outstanding transaction.
module tb_ptw_mem_arbiter;
    import ptw_mem_arbiter_pkg::*;

    localparam int ST_IDLE  = 0;
    localparam int ST_ISSUE = 1;
    localparam int ST_WAIT  = 2;

    logic clk;
    logic rst_n;
    logic ikill;
    logic dkill;
    int   tests_run;
    int   tests_failed;

    cache_req_if  ireq ();
    cache_resp_if iresp ();
    cache_req_if  dreq ();
    cache_resp_if dresp ();
    cache_req_if  memreq ();
    cache_resp_if memresp ();

    ptw_mem_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ireq    (ireq),
        .iresp   (iresp),
        .dreq    (dreq),
        .dresp   (dresp),
        .ikill   (ikill),
        .dkill   (dkill),
        .memreq  (memreq),
        .memresp (memresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq.valid    = 1'b0;
        ireq.addr     = '0;
        ireq.wen      = 1'b0;
        ireq.wdata    = '0;
        dreq.valid    = 1'b0;
        dreq.addr     = '0;
        dreq.wen      = 1'b0;
        dreq.wdata    = '0;
        memreq.ready  = 1'b0;
        memresp.valid = 1'b0;
        memresp.rdata = '0;
        ikill         = 1'b0;
        dkill         = 1'b0;
    endtask

    // Entered in IDLE with the requester valids already set; memory accepts at
    // once and answers in the first WAIT cycle.
    task automatic serve(input logic exp_d, input logic [31:0] exp_addr, input logic [31:0] rd);
        #1;
        chk("grant_i_ready", 64'(ireq.ready), 64'(!exp_d));
        chk("grant_d_ready", 64'(dreq.ready), 64'(exp_d));
        nxt();
        memreq.ready = 1'b1;
        #1;
        chk("issue_state", 64'(dut.state), ST_ISSUE);
        chk("issue_addr", 64'(memreq.addr), 64'(exp_addr));
        chk("issue_no_ready", 64'(ireq.ready | dreq.ready), 0);
        nxt();
        memreq.ready  = 1'b0;
        memresp.valid = 1'b1;
        memresp.rdata = rd;
        #1;
        chk("route_iresp", 64'(iresp.valid), 64'(!exp_d));
        chk("route_dresp", 64'(dresp.valid), 64'(exp_d));
        chk("route_rdata", 64'(exp_d ? dresp.rdata : iresp.rdata), 64'(rd));
        nxt();
        memresp.valid = 1'b0;
        #1;
        chk("done_state", 64'(dut.state), ST_IDLE);
        chk("done_ptr", 64'(dut.ptr), 64'(!exp_d));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state; ready is combinational even while held in reset.
        repeat (2) @(posedge clk);
        #1;
        ireq.valid = 1'b1;
        #1;
        chk("rst_state", 64'(dut.state), ST_IDLE);
        chk("rst_ptr", 64'(dut.ptr), 0);
        chk("rst_memreq_valid", 64'(memreq.valid), 0);
        chk("rst_iresp_valid", 64'(iresp.valid), 0);
        chk("rst_dresp_valid", 64'(dresp.valid), 0);
        chk("rst_i_ready", 64'(ireq.ready), 1);
        chk("rst_d_ready", 64'(dreq.ready), 0);
        ireq.valid = 1'b0;
        nxt();
        rst_n = 1'b1;

        // Single instruction-side request, response two cycles after handshake.
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_1000;
        #1;
        chk("t1_i_ready", 64'(ireq.ready), 1);
        chk("t1_d_ready", 64'(dreq.ready), 0);
        nxt();
        ireq.valid   = 1'b0;
        memreq.ready = 1'b1;
        #1;
        chk("t1_memreq_valid", 64'(memreq.valid), 1);
        chk("t1_memreq_addr", 64'(memreq.addr), 64'h8000_1000);
        nxt();
        memreq.ready = 1'b0;
        #1;
        chk("t1_wait_memreq_valid", 64'(memreq.valid), 0);
        chk("t1_wait_iresp_idle", 64'(iresp.valid), 0);
        nxt();
        memresp.valid = 1'b1;
        memresp.rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_iresp_valid", 64'(iresp.valid), 1);
        chk("t1_iresp_rdata", 64'(iresp.rdata), 64'hDEAD_BEEF);
        chk("t1_dresp_valid", 64'(dresp.valid), 0);
        nxt();
        memresp.valid = 1'b0;
        #1;
        chk("t1_iresp_one_cycle", 64'(iresp.valid), 0);
        chk("t1_back_idle", 64'(dut.state), ST_IDLE);

        // A stray memory response in IDLE is ignored.
        memresp.valid = 1'b1;
        #1;
        chk("idle_resp_iresp", 64'(iresp.valid), 0);
        chk("idle_resp_dresp", 64'(dresp.valid), 0);
        nxt();
        memresp.valid = 1'b0;
        #1;
        chk("idle_resp_state", 64'(dut.state), ST_IDLE);

        // Fresh reset, then both requesting continuously: i,d,i,d,i,d.
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        ireq.valid = 1'b1;
        ireq.addr  = 32'h0000_1000;
        dreq.valid = 1'b1;
        dreq.addr  = 32'h0000_2000;
        serve(1'b0, 32'h0000_1000, 32'hA000_0001);
        serve(1'b1, 32'h0000_2000, 32'hA000_0002);
        serve(1'b0, 32'h0000_1000, 32'hA000_0003);
        serve(1'b1, 32'h0000_2000, 32'hA000_0004);
        serve(1'b0, 32'h0000_1000, 32'hA000_0005);
        serve(1'b1, 32'h0000_2000, 32'hA000_0006);
        ireq.valid = 1'b0;

        // Kill of the data walker while it holds ISSUE with memory stalled.
        #1;
        chk("k1_d_ready", 64'(dreq.ready), 1);
        nxt();
        dreq.valid = 1'b0;
        dkill      = 1'b1;
        ireq.valid = 1'b1;
        ireq.addr  = 32'h0000_3000;
        #1;
        chk("k1_issue_state", 64'(dut.state), ST_ISSUE);
        chk("k1_issue_valid", 64'(memreq.valid), 1);
        chk("k1_issue_addr", 64'(memreq.addr), 64'h0000_2000);
        chk("k1_issue_i_ready", 64'(ireq.ready), 0);
        nxt();
        dkill = 1'b0;
        #1;
        chk("k1_abort_state", 64'(dut.state), ST_IDLE);
        chk("k1_abort_ptr", 64'(dut.ptr), 0);
        chk("k1_abort_memreq", 64'(memreq.valid), 0);
        chk("k1_new_i_ready", 64'(ireq.ready), 1);
        nxt();
        ireq.valid   = 1'b0;
        memreq.ready = 1'b1;
        #1;
        chk("k1_new_issue", 64'(dut.state), ST_ISSUE);
        chk("k1_new_addr", 64'(memreq.addr), 64'h0000_3000);
        nxt();
        memreq.ready  = 1'b0;
        memresp.valid = 1'b1;
        memresp.rdata = 32'h0000_0055;
        #1;
        chk("k1_new_iresp", 64'(iresp.valid), 1);
        chk("k1_new_dresp", 64'(dresp.valid), 0);
        nxt();
        memresp.valid = 1'b0;

        // Kill of the instruction walker in WAIT; response 4 cycles after handshake.
        ireq.valid = 1'b1;
        ireq.addr  = 32'h0000_4000;
        #1;
        chk("k2_i_ready", 64'(ireq.ready), 1);
        nxt();
        ireq.valid   = 1'b0;
        memreq.ready = 1'b1;
        nxt();
        memreq.ready = 1'b0;
        ikill        = 1'b1;
        #1;
        chk("k2_wait_state", 64'(dut.state), ST_WAIT);
        nxt();
        ikill = 1'b0;
        #1;
        chk("k2_drop_set", 64'(dut.drop), 1);
        nxt();
        nxt();
        memresp.valid = 1'b1;
        memresp.rdata = 32'h1234_5678;
        #1;
        chk("k2_iresp_dropped", 64'(iresp.valid), 0);
        chk("k2_dresp_quiet", 64'(dresp.valid), 0);
        nxt();
        memresp.valid = 1'b0;
        #1;
        chk("k2_back_idle", 64'(dut.state), ST_IDLE);
        chk("k2_ptr", 64'(dut.ptr), 1);
        ireq.valid = 1'b1;
        ireq.addr  = 32'h0000_5000;
        serve(1'b0, 32'h0000_5000, 32'hCAFE_F00D);
        ireq.valid = 1'b0;

        // Reset while the data walker waits for its response.
        dreq.valid = 1'b1;
        dreq.addr  = 32'h0000_6000;
        #1;
        chk("r_d_ready", 64'(dreq.ready), 1);
        nxt();
        dreq.valid   = 1'b0;
        memreq.ready = 1'b1;
        nxt();
        memreq.ready = 1'b0;
        #1;
        chk("r_wait_state", 64'(dut.state), ST_WAIT);
        rst_n = 1'b0;
        #1;
        chk("r_state", 64'(dut.state), ST_IDLE);
        chk("r_memreq_valid", 64'(memreq.valid), 0);
        chk("r_ptr", 64'(dut.ptr), 0);
        chk("r_dresp_valid", 64'(dresp.valid), 0);
        nxt();
        rst_n      = 1'b1;
        ireq.valid = 1'b1;
        ireq.addr  = 32'h0000_7000;
        serve(1'b0, 32'h0000_7000, 32'h0BAD_F00D);
        ireq.valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ptw_mem_arbiter.md
# ptw_mem_arbiter

Two-requester arbiter that shares the single memory-side `CacheReq`/`CacheResp` port between the instruction-side and data-side page table walkers. It sits between the two `PageTableWalker` instances' `memreq`/`memresp` ports and the memory/cache port. It allows exactly one outstanding transaction, uses round-robin priority, and routes each response back to the requester that issued it. A per-requester kill aborts or discards that requester's transaction without corrupting the memory-side handshake.

## Interface
- `LOG_ENABLE`, 0, enables `PRINT_DEBUGINFO` data lines (state, owner, pointer, drop flag).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ireq`  inout  CacheReq  requester 0 (instruction PTW) request: valid/addr/wen/wdata in, ready out.
- `iresp`  inout  CacheResp  requester 0 response: valid/rdata out.
- `dreq`  inout  CacheReq  requester 1 (data PTW) request.
- `dresp`  inout  CacheResp  requester 1 response.
- `ikill`  in  1  abort requester 0's transaction.
- `dkill`  in  1  abort requester 1's transaction.
- `memreq`  inout  CacheReq  memory-side request: valid/addr/wen/wdata out, ready in.
- `memresp`  inout  CacheResp  memory-side response: valid/rdata in.

## Operation
- State machine `IDLE`, `ISSUE`, `WAIT`. Registers: `state`, `owner` (1 bit), `ptr` (round-robin pointer, 1 bit), `drop` (1 bit), `s_req` (latched CacheReq).
- Winner in IDLE:
  - If only one valid is asserted, that requester wins.
  - If both are asserted, `ptr` wins.
  - `ireq.ready = state==IDLE && winner==0`.
  - `dreq.ready = state==IDLE && winner==1`.
  - A requester's `ready` is never asserted outside IDLE.
- IDLE, when either valid is asserted and the winner's kill is low:
  - Latch the winner's addr/wen/wdata into `s_req`.
  - Set `owner` to the winner and clear `drop`.
  - Go to ISSUE.
  - A winner whose kill is high is not accepted that cycle: ready is still driven, but nothing is latched.
- ISSUE:
  - `memreq.valid=1`, with fields from `s_req`.
  - If the owner's kill is high, go to IDLE. No memory transaction occurs and `memreq.valid` is still 1 that cycle; kill takes precedence only if `memreq.ready` is low.
  - If `memreq.ready` is high (and not aborted per the previous rule), go to WAIT, setting `drop` if the owner's kill is also high.
- WAIT:
  - `memreq.valid=0`.
  - The owner's kill sets `drop`.
  - When `memresp.valid` is high, go to IDLE and set `ptr <= ~owner`.
  - The response is forwarded combinationally: `<owner>resp.valid = memresp.valid && !drop && !kill_owner`, `rdata` passes through.
  - The non-owner's `resp.valid` stays 0.
- `ptr` updates only on a completed or dropped WAIT response. An abort in ISSUE leaves `ptr` unchanged.
- The non-owner's kill has no effect on the active transaction.
- Both `resp.rdata` outputs are always driven from `memresp.rdata`.

## Timing
- Reset values (async assert, sync release):
  - Registers: `state=IDLE`, `ptr=0`, `owner=0`, `drop=0`, `s_req=0`.
  - Outputs: `memreq.valid=0`, both `resp.valid=0`.
  - `ready` is combinational, i.e. high for the winner if that requester's valid is high.
- Accept cycle N → `memreq.valid` high at N+1.
- Minimum request-to-response latency is 2 cycles plus the memory latency. `resp.valid` appears in the same cycle as `memresp.valid`, with no added register.
- Back-to-back throughput is one transaction per 3 cycles at minimum: IDLE, ISSUE, and the WAIT response cycle.
- A `memresp.valid` seen in IDLE or ISSUE is ignored.
- Reset mid-transaction returns to IDLE. The memory side is assumed to be reset by the same `rst_n`.

## Structure
- `CacheReq`/`CacheResp` and `modetype` stay in the existing shared package.
- The `statetype` enum (`IDLE`, `ISSUE`, `WAIT`) is local to the module.
- No sub-module. A 2-way round-robin pick is a few gates inline.

## Test plan
- Single request: `ireq` valid, addr 0x8000_1000, memory ready immediately, rdata 0xDEADBEEF two cycles later → `iresp.valid` for 1 cycle with 0xDEADBEEF; `dresp.valid` stays 0; `memreq.addr` = 0x8000_1000.
- Simultaneous requests after reset: both valid, `i`@0x1000, `d`@0x2000 → `i` served first (`ptr=0`), then `d`; the next simultaneous pair is served `i` first again, since `ptr` returns to 0 after `d` completes.
- Round-robin fairness: both valid continuously for 6 transactions → grant order i,d,i,d,i,d; each response is routed only to its issuer.
- Kill in ISSUE: `memreq.ready` held low, assert `dkill` while `d` owns ISSUE → next state IDLE, no `memreq` handshake, `ptr` unchanged, a new `i` request is accepted the following cycle.
- Kill in WAIT: `ikill` pulse after `memreq` handshake, response 0x12345678 arrives 4 cycles later → `iresp.valid` stays 0, FSM returns to IDLE on that cycle, and the next transaction's data is not polluted.
- Reset mid-WAIT: deassert `rst_n` during WAIT → immediately IDLE, `memreq.valid=0`, `ptr=0`; post-reset `ireq` completes normally.
